mvm_transpose: RTL
==================

Name: mvm_transpose

Overview:
Transposed matrix-vector multiplier for the backpropagation path. It computes result[r] = sum over c of matrix[r][c] * vector[c], i.e. M·v, where v has MATRIX_WIDTH entries.
- Uses the same flattened matrix layout as the forward mvm block, which computes vᵀ·M.
- Propagates output-layer errors back through the same weight matrix, without re-packing it.
- Sequential, tiled MAC engine with a start/valid handshake.

Parameters:
MATRIX_WIDTH, 20, number of columns; size of input vector
MATRIX_HEIGHT, 5, number of rows; size of result vector
VECTOR_CELL_WIDTH, 8, bits per vector element (signed two's complement)
MATRIX_CELL_WIDTH, 8, bits per matrix element (signed two's complement)
TILING_ROW, 1, rows accumulated in parallel per pass (1..MATRIX_HEIGHT)
TILING_COL, 1, products summed per accumulator per cycle (1..MATRIX_WIDTH)
Local: RESULT_WIDTH = VECTOR_CELL_WIDTH + MATRIX_CELL_WIDTH + log2(MATRIX_WIDTH) + 1 (ceil log2).

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle request; operands sampled on this edge
vector  input  MATRIX_WIDTH*VECTOR_CELL_WIDTH  element c at [c*VECTOR_CELL_WIDTH +: VECTOR_CELL_WIDTH]
matrix  input  MATRIX_WIDTH*MATRIX_HEIGHT*MATRIX_CELL_WIDTH  element (r,c) at [(r*MATRIX_WIDTH+c)*MATRIX_CELL_WIDTH +: MATRIX_CELL_WIDTH]
result  output  MATRIX_HEIGHT*RESULT_WIDTH  element r at [r*RESULT_WIDTH +: RESULT_WIDTH], signed
valid  output  1  one-cycle pulse: result updated

Behaviour:
- Reset values: result = 0, valid = 0, FSM = IDLE, counters = 0. Reset is synchronous and wins over everything, including mid-computation; the partial result is discarded.
- start in IDLE: latch vector and matrix into internal registers. Caller may change inputs afterwards. Go to CALC; clear row_pass = 0, col_chunk = 0, accumulators = 0.
- start in CALC or DONE: ignored; no restart and no effect on the running operation.
- CALC, each cycle: for each lane t in 0..TILING_ROW-1:
  - row r = row_pass*TILING_ROW + t; columns c = col_chunk*TILING_COL + k, for k in 0..TILING_COL-1.
  - Accumulate the sum of the signed products matrix[r][c]*vector[c] into accumulator t.
  - Out-of-range r or c contributes 0 (ragged tiles zero-padded).
- Counter sequencing:
  - col_chunk counts 0..C-1, with C = ceil(MATRIX_WIDTH/TILING_COL).
  - On the last chunk, write each in-range lane's final sum into result[r], clear the accumulators, reset col_chunk, and increment row_pass.
  - row_pass counts 0..P-1, with P = ceil(MATRIX_HEIGHT/TILING_ROW). The last chunk of the last pass moves the FSM to DONE.
- DONE: assert valid for exactly one cycle, then return to IDLE.
- Latency: start sampled at edge 0; valid high in the cycle after edge P*C+1. TILING_ROW=TILING_COL=1 at defaults gives 101 cycles.
- result rows update progressively during CALC. Only the value while valid=1 (and until the next accepted start) is architecturally defined.
- result holds its value in IDLE until overwritten by the next computation.
- Arithmetic:
  - Products are sign-extended to RESULT_WIDTH before accumulation.
  - No saturation; RESULT_WIDTH is sized so a full-range sum cannot overflow.
- Back-to-back: a start in the cycle valid is high is ignored, because the FSM is in DONE. The earliest accepted restart is the cycle after valid.

Optional Feature:
MVM_TRANSPOSE_BUSY_EN
- Defined: adds output port busy (1 bit, reset 0).
  - High from the cycle after start is accepted through the cycle valid is high.
  - Low in IDLE.
  - Lets the upstream controller gate start.
- Undefined: no busy port; start while busy is silently ignored, as above.

Test Plan:
- Default params; matrix[r][c] = r*20+c+1; vector all 1; reset, then start: valid 101 cycles after start, result = {210, 610, 1010, 1410, 1810} for r = 0..4.
- Same matrix, vector one-hot 1 at c=3: result = {4, 24, 44, 64, 84}.
- Same matrix, vector all 8'hFF (-1): result = {-210, -610, -1010, -1410, -1810} as 22-bit two's complement.
- TILING_ROW=2, TILING_COL=3 (ragged P=3, C=7), all-ones vector: identical results to scenario 1; valid 22 cycles after start.
- Pulse start again at cycle 40 of a run, then assert rst at cycle 60: the second start is ignored; after rst, result = 0 and valid never pulses; a fresh start then completes normally.
- MVM_TRANSPOSE_BUSY_EN defined: busy rises the cycle after start and falls after the valid cycle; busy is 0 after rst.

Source files
------------

// File: rtl/mvm_transpose.sv
// rtl/mvm_transpose.sv - tiled sequential M*v multiplier (optional busy output via MVM_TRANSPOSE_BUSY_EN)
module mvm_transpose #(
    parameter int MATRIX_WIDTH      = 20,
    parameter int MATRIX_HEIGHT     = 5,
    parameter int VECTOR_CELL_WIDTH = 8,
    parameter int MATRIX_CELL_WIDTH = 8,
    parameter int TILING_ROW        = 1,
    parameter int TILING_COL        = 1,
    localparam int RESULT_WIDTH = VECTOR_CELL_WIDTH + MATRIX_CELL_WIDTH + $clog2(MATRIX_WIDTH) + 1
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  start,
    input  logic [MATRIX_WIDTH*VECTOR_CELL_WIDTH-1:0]             vector,
    input  logic [MATRIX_WIDTH*MATRIX_HEIGHT*MATRIX_CELL_WIDTH-1:0] matrix,
    output logic [MATRIX_HEIGHT*RESULT_WIDTH-1:0]                 result,
    output logic                                                  valid
`ifdef MVM_TRANSPOSE_BUSY_EN
    ,
    output logic                                                  busy
`endif
);

    localparam int PASSES = (MATRIX_HEIGHT + TILING_ROW - 1) / TILING_ROW;
    localparam int CHUNKS = (MATRIX_WIDTH + TILING_COL - 1) / TILING_COL;
    localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int PRODW  = VECTOR_CELL_WIDTH + MATRIX_CELL_WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_next;

    logic [MATRIX_WIDTH*VECTOR_CELL_WIDTH-1:0]               vec_q;
    logic [MATRIX_WIDTH*MATRIX_HEIGHT*MATRIX_CELL_WIDTH-1:0] mat_q;
    logic [PW-1:0] row_pass;
    logic [CW-1:0] col_chunk;
    logic signed [RESULT_WIDTH-1:0] acc      [TILING_ROW];
    logic signed [RESULT_WIDTH-1:0] lane_sum [TILING_ROW];
    int                             lane_row [TILING_ROW];
    int                             col_idx;
    logic signed [MATRIX_CELL_WIDTH-1:0] m_el;
    logic signed [VECTOR_CELL_WIDTH-1:0] v_el;
    logic signed [PRODW-1:0]             prod;
    logic last_chunk, last_pass;

    assign last_chunk = (col_chunk == CW'(CHUNKS - 1));
    assign last_pass  = (row_pass == PW'(PASSES - 1));

`ifdef MVM_TRANSPOSE_BUSY_EN
    assign busy = (state != IDLE);
`endif

    // Ragged tiles: lanes/columns beyond the matrix edge simply add nothing.
    always_comb begin
        col_idx = 0;
        m_el    = '0;
        v_el    = '0;
        prod    = '0;
        for (int t = 0; t < TILING_ROW; t++) begin
            lane_row[t] = int'(row_pass) * TILING_ROW + t;
            lane_sum[t] = acc[t];
            for (int k = 0; k < TILING_COL; k++) begin
                col_idx = int'(col_chunk) * TILING_COL + k;
                if (lane_row[t] < MATRIX_HEIGHT && col_idx < MATRIX_WIDTH) begin
                    m_el = mat_q[(lane_row[t]*MATRIX_WIDTH + col_idx)*MATRIX_CELL_WIDTH +: MATRIX_CELL_WIDTH];
                    v_el = vec_q[col_idx*VECTOR_CELL_WIDTH +: VECTOR_CELL_WIDTH];
                    prod = PRODW'(m_el) * PRODW'(v_el);
                    lane_sum[t] = lane_sum[t] + RESULT_WIDTH'(prod);
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (last_chunk && last_pass) state_next = DONE;
            DONE:    if (valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // DONE spans two cycles so the valid cycle itself still rejects start.
    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            valid     <= 1'b0;
            row_pass  <= '0;
            col_chunk <= '0;
            vec_q     <= '0;
            mat_q     <= '0;
            for (int t = 0; t < TILING_ROW; t++) acc[t] <= '0;
        end else begin
            valid <= (state == DONE) && !valid;
            case (state)
                IDLE: begin
                    if (start) begin
                        vec_q     <= vector;
                        mat_q     <= matrix;
                        row_pass  <= '0;
                        col_chunk <= '0;
                        for (int t = 0; t < TILING_ROW; t++) acc[t] <= '0;
                    end
                end
                CALC: begin
                    if (last_chunk) begin
                        for (int t = 0; t < TILING_ROW; t++) begin
                            if (lane_row[t] < MATRIX_HEIGHT)
                                result[lane_row[t]*RESULT_WIDTH +: RESULT_WIDTH] <= lane_sum[t];
                            acc[t] <= '0;
                        end
                        col_chunk <= '0;
                        row_pass  <= last_pass ? '0 : row_pass + 1'b1;
                    end else begin
                        for (int t = 0; t < TILING_ROW; t++) acc[t] <= lane_sum[t];
                        col_chunk <= col_chunk + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
